// File: rtl/ssp_rx_timeout_tick.sv
// ---------------------------------------------------------------------------
// ssp_rx_timeout_tick
//
// Purpose
//   Bit-period timebase and receive-activity detector that feeds the SSP
//   receive-idle detector.  Runs entirely in the SSPCLK domain.
//     - IncRxTimeOut_o : one-cycle pulse per serial bit period, where the bit
//                        period is DivEff*(SCR+1) SSPCLK cycles.
//     - MRxRT_o        : one-cycle pulse one cycle after the master core
//                        samples a receive bit.
//     - SRxRT_o        : one-cycle pulse one cycle after an active SCLK edge
//                        is seen in slave mode.
//   Any receive activity (or the block being disabled) restarts the
//   timebase, so the idle count downstream is aligned to the last bit seen.
//
// Parameters
//   CNT_W          width of CPSDVSR/SCR and of both internal counters
//
// Ports
//   SSPCLK_i       main SSP clock, only clock of the block
//   SSPRST_i       asynchronous active-high reset
//   SSE_i          SSP enable, already synchronous to SSPCLK
//   MS_i           0 = master, 1 = slave
//   SPO_i          SCLK polarity: 0 = rising edge active, 1 = falling edge
//   CPSDVSR_i      clock prescale divisor (LSB ignored, minimum 2)
//   SCR_i          serial clock rate
//   MRxBit_i       master core sampled an Rx bit (1-cycle pulse)
//   SCLKINSync_i   synchronised slave serial clock
//   IncRxTimeOut_o bit-period tick (1-cycle pulse)
//   MRxRT_o        master Rx activity / reload pulse
//   SRxRT_o        slave Rx activity / reload pulse
// ---------------------------------------------------------------------------
module ssp_rx_timeout_tick #(
    parameter int CNT_W = 8
) (
    input  logic             SSPCLK_i,
    input  logic             SSPRST_i,
    input  logic             SSE_i,
    input  logic             MS_i,
    input  logic             SPO_i,
    input  logic [CNT_W-1:0] CPSDVSR_i,
    input  logic [CNT_W-1:0] SCR_i,
    input  logic             MRxBit_i,
    input  logic             SCLKINSync_i,
    output logic             IncRxTimeOut_o,
    output logic             MRxRT_o,
    output logic             SRxRT_o
);

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(2);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] pre_cnt_q, pre_cnt_d;   // prescaler, counts DivEff-1..0
    logic [CNT_W-1:0] scr_cnt_q, scr_cnt_d;   // rate counter, counts SCR..0
    logic             sclk_del_q;             // SCLKINSync one cycle ago
    logic             inc_q, inc_d;
    logic             mrxrt_q, mrxrt_d;
    logic             srxrt_q, srxrt_d;

    // -----------------------------------------------------------------------
    // Effective divisor: the LSB of CPSDVSR is dropped and anything below 2
    // is forced to 2, so the prescaler reload value is always at least 1.
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] cps_even;
    logic [CNT_W-1:0] div_eff;
    logic [CNT_W-1:0] pre_reload;

    always_comb begin
        cps_even   = CPSDVSR_i & ~ONE;
        div_eff    = (cps_even < DIV_MIN) ? DIV_MIN : cps_even;
        pre_reload = div_eff - ONE;
    end

    // -----------------------------------------------------------------------
    // Activity detect
    // A slave edge is a change on SCLKINSync whose new level matches the
    // active level for the selected polarity (rising for SPO=0, falling for
    // SPO=1).  The delay register tracks SCLKINSync even while disabled, so
    // a line that is already high when SSE rises is not mistaken for an edge.
    // -----------------------------------------------------------------------
    logic m_act;
    logic s_act;
    logic sclk_edge;
    logic sclk_active_lvl;
    logic restart;

    always_comb begin
        sclk_edge       = SCLKINSync_i ^ sclk_del_q;
        sclk_active_lvl = SCLKINSync_i ^ SPO_i;
        m_act           = SSE_i & ~MS_i & MRxBit_i;
        s_act           = SSE_i &  MS_i & sclk_edge & sclk_active_lvl;
        restart         = ~SSE_i | m_act | s_act;
    end

    // -----------------------------------------------------------------------
    // Timebase next state
    // The prescaler reloads from the live CPSDVSR and the rate counter from
    // the live SCR only at their reload points, so a divisor change never
    // truncates the count in progress.  Restart takes priority over a
    // terminal count in the same cycle, which suppresses that tick.
    // -----------------------------------------------------------------------
    logic pre_tc;
    logic scr_tc;

    always_comb begin
        pre_tc    = (pre_cnt_q == '0);
        scr_tc    = (scr_cnt_q == '0);

        pre_cnt_d = pre_cnt_q;
        scr_cnt_d = scr_cnt_q;
        inc_d     = 1'b0;

        if (restart) begin
            pre_cnt_d = pre_reload;
            scr_cnt_d = SCR_i;
        end else begin
            inc_d = pre_tc & scr_tc;
            if (pre_tc) begin
                pre_cnt_d = pre_reload;
                scr_cnt_d = scr_tc ? SCR_i : (scr_cnt_q - ONE);
            end else begin
                pre_cnt_d = pre_cnt_q - ONE;
            end
        end

        mrxrt_d = m_act;
        srxrt_d = s_act;
    end

    // -----------------------------------------------------------------------
    // Registers
    // Reset state is equivalent to a restart with DivEff=2, SCR=0, so the
    // first tick after release arrives on the second cycle.
    // -----------------------------------------------------------------------
    always_ff @(posedge SSPCLK_i or posedge SSPRST_i) begin
        if (SSPRST_i) begin
            pre_cnt_q  <= ONE;
            scr_cnt_q  <= '0;
            sclk_del_q <= 1'b0;
            inc_q      <= 1'b0;
            mrxrt_q    <= 1'b0;
            srxrt_q    <= 1'b0;
        end else begin
            pre_cnt_q  <= pre_cnt_d;
            scr_cnt_q  <= scr_cnt_d;
            sclk_del_q <= SCLKINSync_i;
            inc_q      <= inc_d;
            mrxrt_q    <= mrxrt_d;
            srxrt_q    <= srxrt_d;
        end
    end

    assign IncRxTimeOut_o = inc_q;
    assign MRxRT_o        = mrxrt_q;
    assign SRxRT_o        = srxrt_q;

endmodule
